dm_bytelane: RTL and testbench
==============================

Name: dm_bytelane

Overview:
- Parametrised successor to the M-stage word data memory.
- Adds byte and halfword stores through per-lane write enables, plus sign/zero-extended sub-word loads.
- Adds a configurable depth and base address, and address-exception outputs for misaligned or out-of-range accesses.
- Sits in the M stage: combinational read path, synchronous write at posedge clk.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words (default 4096 words = 16 KiB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- PC  input  32  PC of the instruction in M; used only for the write trace.
- MemWrite  input  1  store request this cycle.
- MemRead  input  1  load request this cycle.
- DMOp  input  3  access type: 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed, 5-7 reserved.
- DMaddr  input  32  byte address.
- DMin  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- DMout  output  32  extended load result.
- AdEL  output  1  load address exception.
- AdES  output  1  store address exception.

Behaviour:
- Address decode:
  - off = DMaddr - BASE_ADDR, computed modulo 2^32.
  - inrange = (off >> 2) < 2^DEPTH_LOG2, i.e. off is not wrapped and lies below 4·2^DEPTH_LOG2.
  - idx = off[DEPTH_LOG2+1:2].
  - lane = off[1:0].
- Alignment:
  - Word accesses need lane == 0.
  - Half accesses need lane[0] == 0.
  - Byte accesses are always aligned.
- Exceptions (combinational, same cycle):
  - AdEL = MemRead & !MemWrite & (misaligned | !inrange).
  - AdES = MemWrite & (misaligned | !inrange).
  - Reserved DMOp raises no exception.
- Byte enables for a store:
  - word: 4'b1111.
  - half: 4'b0011 << lane.
  - byte: 4'b0001 << lane.
  - reserved: 4'b0000, so no write.
- Store data is replicated across lanes: half as {2{DMin[15:0]}}, byte as {4{DMin[7:0]}}.
- Write:
  - At posedge clk, when MemWrite & !AdES & !reset, only the enabled byte lanes of mem[idx] are updated.
  - Disabled lanes hold their value.
  - A store raising an exception leaves memory unchanged.
- Read (combinational from the current array contents):
  - Source word w = mem[idx].
  - word: w.
  - half: w[16·lane[1] +: 16], sign-extended for op 2, zero-extended for op 1.
  - byte: w[8·lane +: 8], sign-extended for op 4, zero-extended for op 3.
  - reserved DMOp: 0.
  - Out of range: DMout = 0. Misaligned: DMout = 0.
  - DMout is valid regardless of MemRead (MemRead only gates AdEL).
- Read-before-write: a store at edge N is visible on DMout from just after edge N. In the storing cycle DMout shows the old data.
- Simultaneous MemRead & MemWrite: treated as a store. AdEL is forced 0 and DMout shows pre-write data.
- Reset:
  - At posedge clk with reset = 1, every word is cleared to 0 in that single cycle.
  - Reset has priority over any concurrent store.
  - Outputs have no registered state. After reset, DMout = 0 for every in-range address. AdEL and AdES follow their inputs combinationally.
- Wrap-around: addresses below BASE_ADDR produce a wrapped (huge) off, so inrange = 0. They never alias into the array.

Optional Feature:
- Macro: DM_TRACE_EN.
- When defined, each committed write executes $display("%d@%h: *%h <= %h", $time, PC, {DMaddr[31:2],2'b00}, merged_word).
  - merged_word is the full post-write 32-bit value of the word, with untouched lanes taken from the old contents.
- No line is printed for suppressed stores (exception, reserved op, or reset).
- When undefined, no display code is compiled in. Functional behaviour is identical.

Test Plan:
1. Reset high 1 cycle, then word load at 0x0000_3FFC → DMout = 0, AdEL = 0.
2. sw 0x1234_5678 @0x10, then sb 0xAB @0x11 → lw @0x10 = 0x1234_AB78; lb @0x11 = 0xFFFF_FFAB; lbu @0x11 = 0x0000_00AB.
3. sh 0x8001 @0x22, then lh @0x22 → 0xFFFF_8001; lhu @0x22 → 0x0000_8001; lw @0x20 = 0x8001_0000.
4. sw @0x13 → AdES = 1 and memory unchanged (lw @0x10 still returns the old value); lh @0x21 → AdEL = 1, DMout = 0.
5. Store at 0x0000_4000 with DEPTH_LOG2 = 12 → AdES = 1, no write; store at BASE_ADDR−4 with BASE_ADDR = 0x1000 → AdES = 1.
6. sw 0xDEAD_BEEF @0x40 with reset asserted in the same cycle → lw @0x40 = 0 afterwards; with DM_TRACE_EN, no trace line is printed for it.

Source files
------------

// File: rtl/dm_bytelane.sv
// dm_bytelane: M-stage data memory with byte/half lanes, sub-word loads and address exceptions.
// Define DM_TRACE_EN to print one trace line per committed write.
module dm_bytelane #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  DMOp,
  input  logic [31:0] DMaddr,
  input  logic [31:0] DMin,
  output logic [31:0] DMout,
  output logic        AdEL,
  output logic        AdES
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IW    = DEPTH_LOG2;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HU = 3'd1;
  localparam logic [2:0] OP_H  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd3;
  localparam logic [2:0] OP_B  = 3'd4;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          inrange;
  logic          is_word, is_half, is_byte;
  logic          misaligned, exc, we;
  logic [3:0]    be;
  logic [31:0]   wr_data, w, merged;
  logic [15:0]   hsel;
  logic [7:0]    bsel;

  // Address decode; a wrapped offset (below BASE_ADDR) has high bits set and is out of range.
  always_comb begin
    off        = DMaddr - BASE_ADDR;
    inrange    = (off[31:DEPTH_LOG2+2] == '0);
    idx        = off[DEPTH_LOG2+1:2];
    lane       = off[1:0];
    is_word    = (DMOp == OP_W);
    is_half    = (DMOp == OP_HU) | (DMOp == OP_H);
    is_byte    = (DMOp == OP_BU) | (DMOp == OP_B);
    misaligned = (is_word & (lane != 2'd0)) | (is_half & lane[0]);
    exc        = (is_word | is_half | is_byte) & (misaligned | !inrange);
  end

  assign AdES = MemWrite & exc;
  assign AdEL = MemRead & !MemWrite & exc;

  // Lane enables and replicated store data; reserved ops enable nothing.
  always_comb begin
    be      = 4'b0000;
    wr_data = DMin;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be      = 4'b0011 << lane;
      wr_data = {2{DMin[15:0]}};
    end else if (is_byte) begin
      be      = 4'b0001 << lane;
      wr_data = {4{DMin[7:0]}};
    end
  end

  // Combinational load path from current contents, with extension.
  always_comb begin
    w    = mem[idx];
    hsel = lane[1] ? w[31:16] : w[15:0];
    case (lane)
      2'd0:    bsel = w[7:0];
      2'd1:    bsel = w[15:8];
      2'd2:    bsel = w[23:16];
      default: bsel = w[31:24];
    endcase
    DMout = '0;
    if (inrange & !misaligned) begin
      case (DMOp)
        OP_W:    DMout = w;
        OP_HU:   DMout = {16'h0000, hsel};
        OP_H:    DMout = {{16{hsel[15]}}, hsel};
        OP_BU:   DMout = {24'h00_0000, bsel};
        OP_B:    DMout = {{24{bsel[7]}}, bsel};
        default: DMout = '0;
      endcase
    end
  end

  // Post-write word: enabled lanes from store data, the rest from the old word.
  always_comb begin
    merged = w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    we = MemWrite & !exc & !reset & (be != 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (we) $display("%d@%h: *%h <= %h", $time, PC, {DMaddr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Bench for dm_bytelane: byte-addressed reference model checked every cycle, plus literal expectations.
module tb_dm_bytelane;
  localparam int unsigned DL_A   = 12;
  localparam int unsigned DL_B   = 4;
  localparam logic [31:0] BASE_B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, MemWrite, MemRead;
  logic [2:0]  DMOp;
  logic [31:0] PC, DMaddr, DMin;
  logic [31:0] dmout_a, dmout_b;
  logic        adel_a, ades_a, adel_b, ades_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bit [7:0] mdl_a [int unsigned];
  bit [7:0] mdl_b [int unsigned];

  dm_bytelane #(.DEPTH_LOG2(DL_A), .BASE_ADDR(32'h0000_0000)) u_a (
    .clk(clk), .reset(reset), .PC(PC), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMOp(DMOp), .DMaddr(DMaddr), .DMin(DMin), .DMout(dmout_a), .AdEL(adel_a), .AdES(ades_a));

  dm_bytelane #(.DEPTH_LOG2(DL_B), .BASE_ADDR(BASE_B)) u_b (
    .clk(clk), .reset(reset), .PC(PC), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMOp(DMOp), .DMaddr(DMaddr), .DMin(DMin), .DMout(dmout_b), .AdEL(adel_b), .AdES(ades_b));

  always #5 clk = ~clk;

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit [7:0] rd_byte(input int which, input int unsigned a);
    if (which == 0) return mdl_a.exists(a) ? mdl_a[a] : 8'h00;
    return mdl_b.exists(a) ? mdl_b[a] : 8'h00;
  endfunction

  // Decode for one instance: byte offset, access size, and whether the access is legal.
  function automatic void decode(input int which, output logic [31:0] off, output int sz,
                                 output bit mis, output bit inr);
    logic [31:0]     base;
    longint unsigned nbytes;
    base   = (which == 0) ? 32'h0 : BASE_B;
    nbytes = (which == 0) ? (64'd4 << DL_A) : (64'd4 << DL_B);
    off    = DMaddr - base;
    sz     = op_size(DMOp);
    mis    = (sz != 0) && ((off % sz) != 0);
    inr    = {32'h0, off} < nbytes;
  endfunction

  function automatic void model(input int which, output logic [31:0] dout,
                                output logic adel, output logic ades);
    logic [31:0] off;
    int sz;
    bit mis, inr, exc;
    decode(which, off, sz, mis, inr);
    exc  = (sz != 0) && (mis || !inr);
    ades = MemWrite && exc;
    adel = MemRead && !MemWrite && exc;
    dout = '0;
    if (sz != 0 && !mis && inr) begin
      for (int k = sz - 1; k >= 0; k--) dout = (dout << 8) | {24'h0, rd_byte(which, off + k)};
      if (DMOp == 3'd2) dout = {{16{dout[15]}}, dout[15:0]};
      if (DMOp == 3'd4) dout = {{24{dout[7]}}, dout[7:0]};
    end
  endfunction

  // Model state update at each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      mdl_a.delete();
      mdl_b.delete();
    end else if (MemWrite) begin
      for (int which = 0; which < 2; which++) begin
        logic [31:0] off;
        int sz;
        bit mis, inr;
        decode(which, off, sz, mis, inr);
        if (sz != 0 && !mis && inr) begin
          for (int k = 0; k < sz; k++) begin
            if (which == 0) mdl_a[off + k] = DMin[8*k +: 8];
            else            mdl_b[off + k] = DMin[8*k +: 8];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ed;
      logic el, es;
      model(0, ed, el, es);
      check("A.DMout", dmout_a, ed);
      check("A.AdEL", {31'h0, adel_a}, {31'h0, el});
      check("A.AdES", {31'h0, ades_a}, {31'h0, es});
      model(1, ed, el, es);
      check("B.DMout", dmout_b, ed);
      check("B.AdEL", {31'h0, adel_b}, {31'h0, el});
      check("B.AdES", {31'h0, ades_b}, {31'h0, es});
    end
  end

  // Apply inputs just after a rising edge, then hold until just after the falling edge.
  task automatic step(input bit rst, input bit mw, input bit mr, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] din);
    reset = rst; MemWrite = mw; MemRead = mr; DMOp = op; DMaddr = addr; DMin = din;
    PC = PC + 32'd4;
    @(negedge clk); #1;
  endtask

  task automatic next;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DMOp = 3'd0;
    DMaddr = '0; DMin = '0; PC = 32'h0040_0000;
    @(posedge clk); #1;
    chk_en = 1'b1;

    step(0, 0, 1, 3'd0, 32'h0000_3FFC, 0);
    check("t1 lw 3FFC", dmout_a, 32'h0);
    check("t1 AdEL", {31'h0, adel_a}, 32'h0); next;

    step(0, 1, 0, 3'd0, 32'h10, 32'h1234_5678);
    check("t2 sw old data", dmout_a, 32'h0); next;
    step(0, 1, 0, 3'd3, 32'h11, 32'h5555_55AB); next;
    step(0, 0, 1, 3'd0, 32'h10, 0); check("t2 lw 10", dmout_a, 32'h1234_AB78); next;
    step(0, 0, 1, 3'd4, 32'h11, 0); check("t2 lb 11", dmout_a, 32'hFFFF_FFAB); next;
    step(0, 0, 1, 3'd3, 32'h11, 0); check("t2 lbu 11", dmout_a, 32'h0000_00AB); next;

    step(0, 1, 0, 3'd1, 32'h22, 32'h7777_8001); next;
    step(0, 0, 1, 3'd2, 32'h22, 0); check("t3 lh 22", dmout_a, 32'hFFFF_8001); next;
    step(0, 0, 1, 3'd1, 32'h22, 0); check("t3 lhu 22", dmout_a, 32'h0000_8001); next;
    step(0, 0, 1, 3'd0, 32'h20, 0); check("t3 lw 20", dmout_a, 32'h8001_0000); next;

    step(0, 1, 0, 3'd0, 32'h13, 32'hFFFF_FFFF); check("t4 sw 13 AdES", {31'h0, ades_a}, 32'h1); next;
    step(0, 0, 1, 3'd0, 32'h10, 0); check("t4 lw 10 kept", dmout_a, 32'h1234_AB78); next;
    step(0, 0, 1, 3'd2, 32'h21, 0);
    check("t4 lh 21 AdEL", {31'h0, adel_a}, 32'h1);
    check("t4 lh 21 dout", dmout_a, 32'h0); next;

    step(0, 1, 0, 3'd0, 32'h4000, 32'h9999_9999); check("t5 sw 4000 AdES", {31'h0, ades_a}, 32'h1); next;
    step(0, 0, 1, 3'd0, 32'h0, 0); check("t5 no alias", dmout_a, 32'h0); next;
    step(0, 1, 0, 3'd0, 32'h0FFC, 32'hCAFE_F00D);
    check("t5 B below base AdES", {31'h0, ades_b}, 32'h1);
    check("t5 A in range AdES", {31'h0, ades_a}, 32'h0); next;
    step(0, 0, 1, 3'd0, 32'h0FFC, 0);
    check("t5 A lw FFC", dmout_a, 32'hCAFE_F00D);
    check("t5 B lw FFC AdEL", {31'h0, adel_b}, 32'h1);
    check("t5 B lw FFC dout", dmout_b, 32'h0); next;
    step(0, 1, 0, 3'd0, 32'h1000, 32'h1122_3344); check("t5 B sw base AdES", {31'h0, ades_b}, 32'h0); next;
    step(0, 0, 1, 3'd3, 32'h1003, 0);
    check("t5 B lbu 1003", dmout_b, 32'h11);
    check("t5 A lbu 1003", dmout_a, 32'h11); next;

    step(0, 1, 1, 3'd0, 32'h10, 32'h0BAD_F00D);
    check("rw AdEL forced 0", {31'h0, adel_a}, 32'h0);
    check("rw old data", dmout_a, 32'h1234_AB78); next;
    step(0, 0, 0, 3'd0, 32'h10, 0); check("lw no MemRead", dmout_a, 32'h0BAD_F00D); next;
    step(0, 1, 1, 3'd0, 32'h12, 0);
    check("rw mis AdES", {31'h0, ades_a}, 32'h1);
    check("rw mis AdEL", {31'h0, adel_a}, 32'h0); next;
    step(0, 1, 0, 3'd5, 32'h10, 32'hFFFF_FFFF);
    check("rsv AdES", {31'h0, ades_a}, 32'h0);
    check("rsv dout", dmout_a, 32'h0); next;
    step(0, 0, 1, 3'd0, 32'h10, 0); check("rsv no write", dmout_a, 32'h0BAD_F00D); next;

    step(1, 1, 0, 3'd0, 32'h40, 32'hDEAD_BEEF); next;
    step(0, 0, 1, 3'd0, 32'h40, 0); check("t6 lw 40", dmout_a, 32'h0); next;
    step(0, 0, 1, 3'd0, 32'h10, 0); check("t6 lw 10 cleared", dmout_a, 32'h0); next;
    step(0, 0, 1, 3'd0, 32'h1000, 0); check("t6 B lw base", dmout_b, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
